// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU with pipeline stall and one-cycle ready pulse
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   start_i   operation request with valid operands
//   signed_i  1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i  dividend, divisor
//   annul_i   abandon the current operation
//   stall_o   hold EX and earlier stages
//   ready_o   one-cycle pulse, result_o valid
//   result_o  {remainder, quotient}
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic               neg_q_q, neg_q_d, neg_r_q, neg_r_d, ready_q, ready_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH:0]     sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_step, quo_step, a_mag, b_mag;
    always_comb begin
        // the shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1) compare correctly
        sh       = {rem_q, quo_q[WIDTH-1]};
        ge       = sh >= {1'b0, dvs_q};
        rem_step = ge ? sh[WIDTH-1:0] - dvs_q : sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ge};
        a_mag    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        res_d    = res_q;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (b_i == '0) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        res_d   = {a_i, {WIDTH{1'b1}}};
                    end else begin
                        state_d = BUSY;
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        neg_q_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_r_d = signed_i && a_i[WIDTH-1];
                    end
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        res_d   = {neg_r_q ? -rem_step : rem_step, neg_q_q ? -quo_step : quo_step};
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            ready_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            ready_q <= ready_d;
            res_q   <= res_d;
        end
    end
    assign stall_o  = (state_q == IDLE && start_i && !annul_i) || state_q == BUSY;
    assign ready_o  = ready_q && !annul_i;
    assign result_o = res_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks of div_seq latency, stall, results and annul/reset behaviour
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        annul_i = 1'b0;
    logic        stall_o, ready_o;
    logic [63:0] result_o;
    int          checks = 0;
    int          failures = 0;
    always #5 clk = ~clk;
    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .annul_i(annul_i),
        .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        int   cyc;
        logic stall_ok;
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = sg;
        a_i      = a;
        b_i      = b;
        #4;
        chk({tag, " stall0"}, 64'(stall_o), 64'd1);
        chk({tag, " ready0"}, 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        stall_ok = 1'b1;
        for (cyc = 1; cyc < 60; cyc++) begin
            #4;
            if (ready_o) break;
            stall_ok &= stall_o;
            @(posedge clk);
            #1;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
        chk({tag, " stall_done"}, 64'(stall_o), 64'd0);
        chk({tag, " result"}, result_o, exp);
    endtask
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFFFFFF};
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction
    initial begin
        logic [63:0] prev;
        logic [31:0] ra, rb;
        logic        rs;
        #12;
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("divu100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("div-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_op("div7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
        run_op("div_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
        chk("min_-1 known", 64'($isunknown(result_o)), 64'd0);
        run_op("divu_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, {32'd1, 32'd1}, 33);
        run_op("divu5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1);
        prev = {32'd5, 32'hFFFFFFFF};
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #4;
        chk("annul ready10", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        #4;
        chk("annul stall11", 64'(stall_o), 64'd0);
        chk("annul ready11", 64'(ready_o), 64'd0);
        chk("annul result", result_o, prev);
        run_op("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        a_i     = 32'd1000;
        b_i     = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst ready", 64'(ready_o), 64'd0);
        chk("rst result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("divu9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        run_op("b2b", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 7 == 3) ? 32'd0 : ((i % 3 == 0) ? ($urandom & 32'hFF) : $urandom);
            rs = i[0];
            run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), (rb == 0) ? 1 : 33);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
